fxp_multiplier: RTL



---
 rtl/fxp_mul_pkg.sv | 15 +
 rtl/fxp_multiplier_if.sv | 24 ++
 rtl/fxp_mul_ctrl.sv | 72 +++++++
 rtl/fxp_multiplier.sv | 88 ++++++++
 4 files changed

// File: rtl/fxp_mul_pkg.sv
// rtl/fxp_mul_pkg.sv - shared widths, iteration count and FSM encoding for fxp_multiplier
package fxp_mul_pkg;

  localparam int W     = 10;
  localparam int FRAC  = 4;
  localparam int ITER  = W;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fxp_multiplier_if.sv
// rtl/fxp_multiplier_if.sv - request/result bundle between a requester and fxp_multiplier
interface fxp_multiplier_if;
  import fxp_mul_pkg::*;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] q_out;
  logic         ovf;

  modport master (
    output start, a_in, b_in,
    input  ready, busy, done, q_out, ovf
  );

  modport slave (
    input  start, a_in, b_in,
    output ready, busy, done, q_out, ovf
  );

endinterface

// File: rtl/fxp_mul_ctrl.sv
// rtl/fxp_mul_ctrl.sv - IDLE/RUN/DONE sequencer and iteration counter for the shift-add multiplier
module fxp_mul_ctrl
  import fxp_mul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sclr,
  input  logic start,
  output logic load,
  output logic shift,
  output logic finish,
  output logic ready,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state, counter and datapath strobes; sclr overrides everything including start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    if (sclr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            load    = 1'b1;
          end
        end
        RUN: begin
          shift = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            finish  = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status flags come straight from the state register so they never glitch
  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: rtl/fxp_multiplier.sv
// rtl/fxp_multiplier.sv - 6.4 unsigned shift-add multiplier; FXP_MUL_SAT_EN saturates q_out on overflow
module fxp_multiplier
  import fxp_mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  fxp_multiplier_if.slave  bus
);

  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   q_q, q_d;
  logic           ovf_q, ovf_d;
  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic           load, shift, finish;

  fxp_mul_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclr   (sclr),
    .start  (bus.start),
    .load   (load),
    .shift  (shift),
    .finish (finish),
    .ready  (bus.ready),
    .busy   (bus.busy),
    .done   (bus.done)
  );

  // One add/shift step; B's vacated high bits collect the low half of the product
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    q_d   = q_q;
    ovf_d = ovf_q;
    sum   = acc_q + {1'b0, (b_q[0] ? a_q : {W{1'b0}})};
    // {sum, B} >> 1 equals {acc_next[W-1:0], b_next} because acc_next[W] is always 0
    prod  = {sum, b_q[W-1:1]};
    if (sclr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      a_d   = bus.a_in;
      b_d   = bus.b_in;
      acc_d = '0;
    end else if (shift) begin
      acc_d = {1'b0, sum[W:1]};
      b_d   = {sum[0], b_q[W-1:1]};
      if (finish) begin
        ovf_d = |prod[2*W-1:W+FRAC];
        q_d   = prod[W+FRAC-1:FRAC];
`ifdef FXP_MUL_SAT_EN
        if (ovf_d) q_d = '1;
`else
        q_d   = prod[W+FRAC-1:FRAC];
`endif
      end
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q_out = q_q;
  assign bus.ovf   = ovf_q;

endmodule
